mem_port_arbiter: RTL

- Shares one single-ported, word-addressed-by-byte memory between the instruction-fetch requester (IF) and the data-memory requester (DM, driven by the memRead/memWrite/memDataSize/memIsSigned decode).
- Contains a round-robin arbiter, a request/ready FSM and a wait-state timeout.
- Handles sub-word store lane steering and load alignment/extension.
- Produces a stall signal for the pipeline.

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Round-robin arbitration, pre-checked alignment, wait-state timeout, sub-word lane handling.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic                  if_err,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [1:0]            dm_size,
    input  logic                  dm_signed,
    output logic                  dm_ack,
    output logic                  dm_err,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_lastGrantDm;
    logic [7:0]            r_count;
    logic [1:0]            r_offset;
    logic [1:0]            r_size;
    logic                  r_signed;

    logic                  w_eligIf;
    logic                  w_eligDm;
    logic                  w_grantIf;
    logic                  w_grantDm;
    logic                  w_preErr;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_dmBad;
    logic [3:0]            w_dmBe;
    logic [DATA_WIDTH-1:0] w_dmWdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_loadData;

    // A requester acknowledged this cycle is not eligible, so it cannot be re-issued on its own ack
    assign w_eligIf = if_req & ~if_ack;
    assign w_eligDm = dm_req & ~dm_ack;
    assign stall    = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    always_comb begin
        w_dmBad   = 1'b0;
        w_dmBe    = 4'b1111;
        w_dmWdata = dm_wdata;
        unique case (dm_size)
            2'b00: begin
                w_dmBe    = 4'b0001 << dm_addr[1:0];
                w_dmWdata = {4{dm_wdata[7:0]}};
            end
            2'b01: begin
                w_dmBad   = dm_addr[0];
                w_dmBe    = 4'b0011 << dm_addr[1:0];
                w_dmWdata = {2{dm_wdata[15:0]}};
            end
            2'b10: w_dmBad = |dm_addr[1:0];
            default: w_dmBad = 1'b1;
        endcase
    end

    always_comb begin
        w_shifted  = mem_rdata >> {r_offset, 3'b000};
        w_loadData = mem_rdata;
        unique case (r_size)
            2'b00: w_loadData = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_loadData = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = mem_rdata;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_grantIf   = 1'b0;
        w_grantDm   = 1'b0;
        w_preErr    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_eligIf && w_eligDm) begin
                    w_grantIf = r_lastGrantDm;
                    w_grantDm = ~r_lastGrantDm;
                end else begin
                    w_grantIf = w_eligIf;
                    w_grantDm = w_eligDm;
                end
                if (w_grantIf) begin
                    w_preErr = |if_addr[1:0];
                    if (!w_preErr) w_stateNext = BUSY_IF;
                end
                if (w_grantDm) begin
                    w_preErr = w_dmBad;
                    if (!w_preErr) w_stateNext = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_stateNext = IDLE;
                end else if (r_count == LP_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Memory-side outputs stay frozen while busy; only completion or timeout releases them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_lastGrantDm <= 1'b0;
            r_count       <= 8'd0;
            r_offset      <= 2'b00;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            if_ack        <= 1'b0;
            if_err        <= 1'b0;
            if_rdata      <= '0;
            dm_ack        <= 1'b0;
            dm_err        <= 1'b0;
            dm_rdata      <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'b0000;
            mem_wdata     <= '0;
        end else begin
            r_state <= w_stateNext;
            if_ack  <= 1'b0;
            if_err  <= 1'b0;
            dm_ack  <= 1'b0;
            dm_err  <= 1'b0;
            if (w_grantIf || w_grantDm) r_lastGrantDm <= w_grantDm;
            if (w_grantIf) begin
                if (w_preErr) begin
                    if_ack   <= 1'b1;
                    if_err   <= 1'b1;
                    if_rdata <= '0;
                end else begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be   <= 4'b1111;
                end
            end
            if (w_grantDm) begin
                if (w_preErr) begin
                    dm_ack   <= 1'b1;
                    dm_err   <= 1'b1;
                    dm_rdata <= '0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= dm_we;
                    mem_addr  <= {dm_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be    <= w_dmBe;
                    mem_wdata <= w_dmWdata;
                    r_offset  <= dm_addr[1:0];
                    r_size    <= dm_size;
                    r_signed  <= dm_signed;
                end
            end
            if (w_done || w_timeout) begin
                mem_req <= 1'b0;
                r_count <= 8'd0;
                if (r_state == BUSY_IF) begin
                    if_ack   <= 1'b1;
                    if_err   <= w_timeout;
                    if_rdata <= w_timeout ? '0 : mem_rdata;
                end else begin
                    dm_ack   <= 1'b1;
                    dm_err   <= w_timeout;
                    dm_rdata <= w_timeout ? '0 : w_loadData;
                end
            end else if (r_state != IDLE) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

endmodule
